// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB master arbiter.
// Holds transfer/burst encodings, arbiter states and burst length lookup.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    // SEQ beats that follow the NONSEQ of a fixed-length burst
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HB_WRAP4, HB_INCR4:   return 4'd3;
            HB_WRAP8, HB_INCR8:   return 4'd7;
            HB_WRAP16, HB_INCR16: return 4'd15;
            default:              return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker.
// Scans requests starting just after the last granted index.
module ahb_rr_picker
    import ahb_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_win,
    output logic         o_valid
);

    always_comb begin
        int idx;
        idx     = 0;
        o_win   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(i_last) + k) % N;
            if (!o_valid && i_req[idx]) begin
                o_valid = 1'b1;
                o_win   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter and bus mux in front of one slave port.
// Locks the grant across fixed-length bursts; broadcasts slave responses.
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_AHB = 2,
    parameter int IDX_W   = (NUM_AHB > 1) ? $clog2(NUM_AHB) : 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NUM_AHB-1:0] HBUSREQ,
    output logic [NUM_AHB-1:0] HGRANT,
    input  logic [31:0]        HADDR_M  [NUM_AHB],
    input  logic [1:0]         HTRANS_M [NUM_AHB],
    input  logic               HWRITE_M [NUM_AHB],
    input  logic [2:0]         HSIZE_M  [NUM_AHB],
    input  logic [2:0]         HBURST_M [NUM_AHB],
    input  logic [3:0]         HPROT_M  [NUM_AHB],
    input  logic [31:0]        HWDATA_M [NUM_AHB],
    output logic [31:0]        HADDR_S,
    output logic [1:0]         HTRANS_S,
    output logic               HWRITE_S,
    output logic [2:0]         HSIZE_S,
    output logic [2:0]         HBURST_S,
    output logic [3:0]         HPROT_S,
    output logic [31:0]        HWDATA_S,
    output logic               HSEL_S,
    input  logic               HREADY_S,
    input  logic [31:0]        HRDATA_S,
    input  logic               HRESP_S,
    output logic [NUM_AHB-1:0] HREADY_M,
    output logic [31:0]        HRDATA_M [NUM_AHB],
    output logic [NUM_AHB-1:0] HRESP_M,
    output logic [IDX_W-1:0]   addr_owner
);

    arb_state_e         r_state, w_state_nxt;
    logic [NUM_AHB-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_addr_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_data_owner;
    logic [IDX_W-1:0]   r_last_grant, w_last_nxt;
    logic [3:0]         r_beat_cnt, w_beat_nxt;

    logic               w_granted;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_win;
    logic               w_win_vld;
    logic [NUM_AHB-1:0] w_own_mask;
    logic               w_own_req;
    logic [1:0]         w_own_trans;
    logic               w_others;
    logic               w_own_seq;
    logic               w_lock;
    logic               w_last;
    logic               w_err;
    logic               w_arb;

    assign w_granted = |r_grant;
    assign w_sel     = w_granted ? r_addr_owner : '0;

    assign HADDR_S  = HADDR_M[w_sel];
    assign HTRANS_S = w_granted ? HTRANS_M[w_sel] : HT_IDLE;
    assign HWRITE_S = HWRITE_M[w_sel];
    assign HSIZE_S  = HSIZE_M[w_sel];
    assign HBURST_S = HBURST_M[w_sel];
    assign HPROT_S  = HPROT_M[w_sel];
    assign HSEL_S   = HTRANS_S[1];
    assign HWDATA_S = HWDATA_M[r_data_owner];

    assign HREADY_M = {NUM_AHB{HREADY_S}};
    assign HRESP_M  = {NUM_AHB{HRESP_S}};
    always_comb begin
        for (int i = 0; i < NUM_AHB; i++) begin
            HRDATA_M[i] = HRDATA_S;
        end
    end

    assign HGRANT     = r_grant;
    assign addr_owner = r_addr_owner;

    ahb_rr_picker #(
        .N (NUM_AHB),
        .W (IDX_W)
    ) u_picker (
        .i_req   (HBUSREQ),
        .i_last  (r_last_grant),
        .o_win   (w_win),
        .o_valid (w_win_vld)
    );

    assign w_own_mask  = NUM_AHB'(1) << r_addr_owner;
    assign w_own_req   = HBUSREQ[r_addr_owner];
    assign w_own_trans = HTRANS_M[r_addr_owner];
    assign w_others    = |(HBUSREQ & ~w_own_mask);
    assign w_own_seq   = (w_own_trans == HT_SEQ)
                      || (w_own_trans == HT_BUSY);

    assign w_lock = (r_state == ST_OWN) && HREADY_S
                 && (HTRANS_S == HT_NONSEQ)
                 && (burst_beats(HBURST_S) != 4'd0);
    assign w_last = (r_state == ST_BURST) && HREADY_S
                 && (HTRANS_S == HT_SEQ)
                 && (r_beat_cnt <= 4'd1);
    assign w_err  = (r_state == ST_BURST) && HRESP_S && !HREADY_S;

    // Burst end forces a fresh pick so waiting masters get their turn
    assign w_arb = HREADY_S && (
                       (r_state == ST_IDLE) || w_last
                    || ((r_state == ST_OWN) && !w_lock
                        && (!w_own_req || (w_own_trans == HT_IDLE)
                            || (w_others && !w_own_seq))));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_addr_owner;
        w_last_nxt  = r_last_grant;
        w_beat_nxt  = r_beat_cnt;
        if (w_err) begin
            w_state_nxt = ST_OWN;
            w_beat_nxt  = 4'd0;
        end else if (w_lock) begin
            w_state_nxt = ST_BURST;
            w_beat_nxt  = burst_beats(HBURST_S);
        end else if (w_arb) begin
            w_beat_nxt = 4'd0;
            if (w_win_vld) begin
                w_grant_nxt = NUM_AHB'(1) << w_win;
                w_owner_nxt = w_win;
                w_last_nxt  = w_win;
                w_state_nxt = ST_OWN;
            end else begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        end else if ((r_state == ST_BURST) && HREADY_S
                     && (HTRANS_S == HT_SEQ)) begin
            w_beat_nxt = r_beat_cnt - 4'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_addr_owner <= '0;
            r_data_owner <= '0;
            r_last_grant <= IDX_W'(NUM_AHB - 1);
            r_beat_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_addr_owner <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
            if (HREADY_S) begin
                r_data_owner <= r_addr_owner;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench for ahb_master_arbiter with two masters.
// Stimulus queues expected transfers; a monitor checks each accepted one.
module tb_ahb_master_arbiter;

    localparam int N = 2;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [2:0] SGL  = 3'd0;
    localparam logic [2:0] INC4 = 3'd3;
    localparam logic [2:0] INC8 = 3'd5;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HGRANT;
    logic [31:0]  HADDR_M  [N];
    logic [1:0]   HTRANS_M [N];
    logic         HWRITE_M [N];
    logic [2:0]   HSIZE_M  [N];
    logic [2:0]   HBURST_M [N];
    logic [3:0]   HPROT_M  [N];
    logic [31:0]  HWDATA_M [N];
    logic [31:0]  HADDR_S;
    logic [1:0]   HTRANS_S;
    logic         HWRITE_S;
    logic [2:0]   HSIZE_S;
    logic [2:0]   HBURST_S;
    logic [3:0]   HPROT_S;
    logic [31:0]  HWDATA_S;
    logic         HSEL_S;
    logic         HREADY_S;
    logic [31:0]  HRDATA_S;
    logic         HRESP_S;
    logic [N-1:0] HREADY_M;
    logic [31:0]  HRDATA_M [N];
    logic [N-1:0] HRESP_M;
    logic         addr_owner;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(.NUM_AHB(N)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HBUSREQ(HBUSREQ), .HGRANT(HGRANT),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M),
        .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M),
        .HBURST_M(HBURST_M), .HPROT_M(HPROT_M),
        .HWDATA_M(HWDATA_M),
        .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S),
        .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S),
        .HBURST_S(HBURST_S), .HPROT_S(HPROT_S),
        .HWDATA_S(HWDATA_S), .HSEL_S(HSEL_S),
        .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S),
        .HRESP_S(HRESP_S),
        .HREADY_M(HREADY_M), .HRDATA_M(HRDATA_M),
        .HRESP_M(HRESP_M), .addr_owner(addr_owner)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [2:0]  burst;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    logic pend = 1'b0;
    logic [31:0] pend_d;

    function automatic logic [31:0] wd(input int m);
        return 32'hDA7A_0000 + 32'(m);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic drv(input int m, input logic req, input logic [1:0] tr,
                       input logic [31:0] a, input logic [2:0] b);
        HBUSREQ[m]  = req;
        HTRANS_M[m] = tr;
        HADDR_M[m]  = a;
        HBURST_M[m] = b;
    endtask

    task automatic push(input int m, input logic [31:0] a,
                        input logic [2:0] b);
        exp_t e;
        e.m = m;
        e.addr = a;
        e.burst = b;
        q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        if (HREADY_S && pend) begin
            chk("hwdata", HWDATA_S, pend_d);
            pend = 1'b0;
        end
        if (HSEL_S && HREADY_S) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got addr %h expected none",
                         HADDR_S);
            end else begin
                e = q.pop_front();
                chk("owner", 32'(addr_owner), 32'(e.m));
                chk("haddr", HADDR_S, e.addr);
                chk("hburst", 32'(HBURST_S), 32'(e.burst));
                chk("hprot", 32'(HPROT_S), 32'(e.m + 1));
                pend   = HWRITE_S;
                pend_d = wd(e.m);
            end
        end
    end

    initial begin
        HRESET   = 1'b1;
        HREADY_S = 1'b1;
        HRESP_S  = 1'b0;
        HRDATA_S = 32'h1234_5678;
        HBUSREQ  = '0;
        for (int i = 0; i < N; i++) begin
            HADDR_M[i]  = '0;
            HTRANS_M[i] = ID;
            HWRITE_M[i] = 1'b1;
            HSIZE_M[i]  = 3'd2;
            HBURST_M[i] = SGL;
            HPROT_M[i]  = 4'(i + 1);
            HWDATA_M[i] = wd(i);
        end
        repeat (3) nxt();
        HRESET = 1'b0;
        smp();
        chk("rst_grant", 32'(HGRANT), 32'h0);
        chk("rst_trans", 32'(HTRANS_S), 32'h0);
        chk("rst_hsel", 32'(HSEL_S), 32'h0);
        chk("rst_owner", 32'(addr_owner), 32'h0);
        chk("rst_hwdata", HWDATA_S, wd(0));
        chk("bc_rdata0", HRDATA_M[0], 32'h1234_5678);
        chk("bc_rdata1", HRDATA_M[1], 32'h1234_5678);
        chk("bc_ready", 32'(HREADY_M), 32'h3);

        // idle start: grant one cycle after request
        nxt();
        nxt();
        drv(1, 1'b1, NS, 32'h4000_0010, SGL);
        smp();
        chk("idle_no_grant_yet", 32'(HGRANT), 32'h0);
        nxt();
        push(1, 32'h4000_0010, SGL);
        smp();
        chk("idle_grant", 32'(HGRANT), 32'h2);
        chk("idle_hsel", 32'(HSEL_S), 32'h1);
        nxt();
        drv(1, 1'b0, ID, 32'h0, SGL);
        smp();
        nxt();
        smp();
        chk("idle_release", 32'(HGRANT), 32'h0);

        // round-robin alternation with no gap
        nxt();
        drv(0, 1'b1, NS, 32'h2000, SGL);
        drv(1, 1'b1, NS, 32'h3000, SGL);
        smp();
        for (int k = 0; k < 4; k++) begin
            nxt();
            push(k % 2, (k % 2) ? 32'h3000 : 32'h2000, SGL);
            smp();
            chk("rr_grant", 32'(HGRANT), 32'(1 << (k % 2)));
        end
        nxt();
        drv(0, 1'b0, ID, 32'h0, SGL);
        drv(1, 1'b0, ID, 32'h0, SGL);
        smp();
        nxt();
        smp();
        chk("rr_release", 32'(HGRANT), 32'h0);

        // INCR4 lock with competing request on beat 2
        nxt();
        drv(0, 1'b1, NS, 32'h100, INC4);
        smp();
        nxt();
        push(0, 32'h100, INC4);
        smp();
        chk("b4_grant0", 32'(HGRANT), 32'h1);
        for (int b = 1; b < 4; b++) begin
            nxt();
            drv(0, 1'b1, SQ, 32'h100 + 32'(4 * b), INC4);
            drv(1, 1'b1, NS, 32'h200, SGL);
            push(0, 32'h100 + 32'(4 * b), INC4);
            smp();
            chk("b4_locked", 32'(HGRANT), 32'h1);
        end
        nxt();
        drv(0, 1'b0, ID, 32'h0, SGL);
        push(1, 32'h200, SGL);
        smp();
        chk("b4_handover", 32'(HGRANT), 32'h2);
        nxt();
        drv(1, 1'b0, ID, 32'h0, SGL);
        smp();
        nxt();
        smp();
        chk("b4_release", 32'(HGRANT), 32'h0);

        // wait states in the middle of an INCR4
        nxt();
        drv(0, 1'b1, NS, 32'h300, INC4);
        smp();
        nxt();
        push(0, 32'h300, INC4);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h304, INC4);
        push(0, 32'h304, INC4);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h308, INC4);
        drv(1, 1'b1, NS, 32'h600, SGL);
        HREADY_S = 1'b0;
        for (int w = 0; w < 3; w++) begin
            smp();
            chk("ws_grant", 32'(HGRANT), 32'h1);
            chk("ws_owner", 32'(addr_owner), 32'h0);
            chk("ws_hwdata", HWDATA_S, wd(0));
            if (w < 2) nxt();
        end
        nxt();
        HREADY_S = 1'b1;
        push(0, 32'h308, INC4);
        smp();
        chk("ws_after_grant", 32'(HGRANT), 32'h1);
        nxt();
        drv(0, 1'b1, SQ, 32'h30C, INC4);
        push(0, 32'h30C, INC4);
        smp();
        chk("ws_last_grant", 32'(HGRANT), 32'h1);
        nxt();
        drv(0, 1'b0, ID, 32'h0, SGL);
        push(1, 32'h600, SGL);
        smp();
        chk("ws_handover", 32'(HGRANT), 32'h2);
        nxt();
        drv(1, 1'b0, ID, 32'h0, SGL);
        smp();
        nxt();
        smp();
        chk("ws_release", 32'(HGRANT), 32'h0);

        // ERROR aborts INCR8 on beat 2
        nxt();
        drv(0, 1'b1, NS, 32'h700, INC8);
        smp();
        nxt();
        push(0, 32'h700, INC8);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h704, INC8);
        drv(1, 1'b1, NS, 32'h800, SGL);
        push(0, 32'h704, INC8);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h708, INC8);
        HREADY_S = 1'b0;
        HRESP_S  = 1'b1;
        smp();
        chk("err_hold1", 32'(HGRANT), 32'h1);
        chk("bc_resp", 32'(HRESP_M), 32'h3);
        chk("bc_notready", 32'(HREADY_M), 32'h0);
        nxt();
        HREADY_S = 1'b1;
        drv(0, 1'b0, ID, 32'h0, SGL);
        smp();
        chk("err_hold2", 32'(HGRANT), 32'h1);
        nxt();
        HRESP_S = 1'b0;
        push(1, 32'h800, SGL);
        smp();
        chk("err_regrant", 32'(HGRANT), 32'h2);
        nxt();
        drv(1, 1'b0, ID, 32'h0, SGL);
        smp();
        nxt();
        smp();
        chk("err_release", 32'(HGRANT), 32'h0);

        // synchronous reset during beat 3 of an INCR4
        nxt();
        drv(0, 1'b1, NS, 32'h900, INC4);
        smp();
        nxt();
        push(0, 32'h900, INC4);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h904, INC4);
        push(0, 32'h904, INC4);
        smp();
        nxt();
        drv(0, 1'b1, SQ, 32'h908, INC4);
        push(0, 32'h908, INC4);
        HRESET = 1'b1;
        smp();
        nxt();
        HRESET = 1'b0;
        drv(0, 1'b0, ID, 32'h0, SGL);
        smp();
        chk("mrst_grant", 32'(HGRANT), 32'h0);
        chk("mrst_trans", 32'(HTRANS_S), 32'h0);
        chk("mrst_hsel", 32'(HSEL_S), 32'h0);
        chk("mrst_owner", 32'(addr_owner), 32'h0);
        nxt();
        smp();
        chk("mrst_stay_idle", 32'(HGRANT), 32'h0);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Round-robin arbiter and multiplexer that shares the single AHB slave port of the AHB-to-APB bridge among NUM_AHB requesting masters. The random transaction generator instances are the typical masters.
- Owns bus grant, the address-phase mux, the data-phase (HWDATA) mux and fixed-length-burst locking.
- Broadcasts slave HREADY/HRDATA/HRESP back to all masters.

Parameters:
- NUM_AHB, 2, number of requesting masters (2..8).
- IDX_W, $clog2(NUM_AHB) (min 1), width of owner index; derived, do not override.

Ports:
- HCLK  in  1  AHB clock.
- HRESET  in  1  synchronous active-high reset.
- HBUSREQ  in  1 [NUM_AHB]  per-master bus request.
- HGRANT  out  1 [NUM_AHB]  per-master grant, one-hot or all-zero.
- HADDR_M  in  32 [NUM_AHB]  master address.
- HTRANS_M  in  2 [NUM_AHB]  master transfer type.
- HWRITE_M  in  1 [NUM_AHB]  master write enable.
- HSIZE_M  in  3 [NUM_AHB]  master transfer size.
- HBURST_M  in  3 [NUM_AHB]  master burst type.
- HPROT_M  in  4 [NUM_AHB]  master protection.
- HWDATA_M  in  32 [NUM_AHB]  master write data.
- HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S  out  32/2/1/3/3/4  address phase to slave.
- HWDATA_S  out  32  write data to slave.
- HSEL_S  out  1  slave select.
- HREADY_S  in  1  slave ready.
- HRDATA_S  in  32  slave read data.
- HRESP_S  in  1  slave response, 1 = ERROR.
- HREADY_M  out  1 [NUM_AHB]  HREADY_S broadcast.
- HRDATA_M  out  32 [NUM_AHB]  HRDATA_S broadcast.
- HRESP_M  out  1 [NUM_AHB]  HRESP_S broadcast.
- addr_owner  out  IDX_W  current address-phase owner index (debug/checker).

Behaviour:
- Reset (HRESET=1 at HCLK edge): state=ST_IDLE, HGRANT=0, addr_owner=0, data_owner=0, last_grant=NUM_AHB-1, beat_cnt=0.
  - Combinational slave outputs then read as HTRANS_S=IDLE(00), HSEL_S=0, HWDATA_S=HWDATA_M[0].
  - Reset mid-burst drops the burst with no completion.
- Address mux (combinational): when any HGRANT is set, the slave address-phase outputs equal the fields of master addr_owner; HSEL_S = HTRANS_S[1]. When HGRANT is all zero, HTRANS_S=00 and HSEL_S=0; the other fields follow master 0.
- Data mux: data_owner <= addr_owner on every cycle with HREADY_S=1; HWDATA_S = HWDATA_M[data_owner].
- States:
  - ST_IDLE: no grant.
  - ST_OWN: granted; single transfers or undefined-length INCR.
  - ST_BURST: fixed-length burst locked.
- Arbitration point: HREADY_S=1 and state is ST_IDLE or ST_OWN, and one of:
  - the owner's HBUSREQ=0, or
  - the owner's HTRANS_M=IDLE, or
  - another master requests and the owner's HTRANS_M is not SEQ/BUSY.
- Winner: first requester scanning from last_grant+1 modulo NUM_AHB.
  - The winner's HGRANT is registered, so it takes effect the next cycle. Set last_grant and addr_owner to the winner; go to ST_OWN.
  - If no requests, HGRANT<=0 and go to ST_IDLE.
  - A sole requester that is already the owner stays the owner; no idle gap.
- Latency: request at cycle N on an idle bus -> HGRANT at N+1 -> NONSEQ visible on HTRANS_S at N+1 -> data phase at N+2.
- Burst lock: in ST_OWN, an accepted NONSEQ (HREADY_S=1) with HBURST_S in {WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16} loads beat_cnt=3/7/15 and moves to ST_BURST.
  - Each accepted SEQ decrements beat_cnt. BUSY does not decrement.
  - On the last beat accepted (beat_cnt=0), return to ST_OWN and evaluate arbitration in that same cycle.
  - Grant never changes in ST_BURST, even if HBUSREQ drops.
- ERROR: HRESP_S=1 with HREADY_S=0 (first error cycle) aborts the burst. State goes to ST_OWN, beat_cnt=0, and re-arbitration is permitted at the next HREADY_S=1.
- Wait states: with HREADY_S=0, addr_owner, data_owner, HGRANT and beat_cnt all hold.
- Simultaneous: a new request arriving on the last burst beat is considered in that same arbitration.

Decomposition:
- Package ahb_arb_pkg holds:
  - htrans_e (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - hburst_e;
  - arb_state_e;
  - function burst_beats(hburst) returning 3/7/15/0.
- Sub-module ahb_rr_picker: combinational round-robin, inputs req vector and last_grant, outputs winner index and valid. Everything else lives in one module.

Test Plan:
- Idle start: reset, then HBUSREQ[1]=1 at cycle 5 -> HGRANT[1]=1 at cycle 6, HSEL_S=1 when master 1 drives NONSEQ to 0x4000_0010, HWDATA_S=HWDATA_M[1] at cycle 7.
- Round-robin fairness: masters 0 and 1 request continuously with single NONSEQ transfers -> grants alternate 0,1,0,1 with no idle cycle.
- INCR4 lock: master 0 runs INCR4 from 0x100 while master 1 requests at the 2nd beat -> master 0 keeps the grant for all 4 beats (0x100..0x10C); HGRANT[1] rises on the cycle after the 4th beat is accepted.
- Wait states: slave holds HREADY_S=0 for 3 cycles mid-burst -> beat_cnt, owners and HWDATA_S all stable; burst completes with exactly 4 accepted beats.
- ERROR abort: HRESP_S=1 on beat 2 of an INCR8 -> state returns to ST_OWN; pending master 1 is granted after HREADY_S=1.
- Reset mid-burst: HRESET=1 during beat 3 -> next cycle HGRANT=0, HTRANS_S=00, HSEL_S=0.
